// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU operation codes, control bundle
// and immediate extension helper.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALU_OP_W = 4;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_LUI   = 4'd5,
    ALU_FUNCT = 4'd6
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_JUMP  = 2'd3
  } imm_sel_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    logic    illegal;
    alu_op_t alu_op;
  } ctrl_t;

  // Builds the 32-bit immediate from the low 26 instruction bits.
  function automatic logic [INSTR_W-1:0] extend_imm(input imm_sel_t sel,
                                                    input logic [25:0] field);
    logic [INSTR_W-1:0] imm;
    case (sel)
      IMM_ZERO:  imm = {16'h0000, field[15:0]};
      IMM_UPPER: imm = {field[15:0], 16'h0000};
      IMM_JUMP:  imm = {6'b000000, field};
      default:   imm = {{16{field[15]}}, field[15:0]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_decoder.sv
// Combinational opcode decode: control bundle, destination select, rt-usage
// flag for hazard detection, and extended immediate.
module id_decoder
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output ctrl_t              o_ctrl_c,
  output logic               o_dest_rd_c,
  output logic               o_reads_rt_c,
  output logic [INSTR_W-1:0] o_imm_c
);

  logic [OPCODE_W-1:0] w_opcode;
  imm_sel_t            w_imm_sel;

  assign w_opcode = i_instr[31:26];

  always_comb begin
    o_ctrl_c        = '0;
    o_ctrl_c.alu_op = ALU_ADD;
    o_dest_rd_c     = 1'b0;
    o_reads_rt_c    = 1'b0;
    w_imm_sel       = IMM_SIGN;
    case (w_opcode)
      OP_RTYPE: begin
        o_ctrl_c.reg_write = 1'b1;
        o_ctrl_c.alu_op    = ALU_FUNCT;
        o_dest_rd_c        = 1'b1;
        o_reads_rt_c       = 1'b1;
      end
      OP_LW: begin
        o_ctrl_c.mem_read   = 1'b1;
        o_ctrl_c.mem_to_reg = 1'b1;
        o_ctrl_c.alu_src    = 1'b1;
        o_ctrl_c.reg_write  = 1'b1;
      end
      OP_SW: begin
        o_ctrl_c.mem_write = 1'b1;
        o_ctrl_c.alu_src   = 1'b1;
        o_reads_rt_c       = 1'b1;
      end
      OP_BEQ: begin
        o_ctrl_c.branch = 1'b1;
        o_ctrl_c.alu_op = ALU_SUB;
        o_reads_rt_c    = 1'b1;
      end
      OP_J: begin
        o_ctrl_c.jump = 1'b1;
        w_imm_sel     = IMM_JUMP;
      end
      OP_ADDI: begin
        o_ctrl_c.alu_src   = 1'b1;
        o_ctrl_c.reg_write = 1'b1;
      end
      OP_SLTI: begin
        o_ctrl_c.alu_src   = 1'b1;
        o_ctrl_c.reg_write = 1'b1;
        o_ctrl_c.alu_op    = ALU_SLT;
      end
      OP_ANDI: begin
        o_ctrl_c.alu_src   = 1'b1;
        o_ctrl_c.reg_write = 1'b1;
        o_ctrl_c.alu_op    = ALU_AND;
        w_imm_sel          = IMM_ZERO;
      end
      OP_ORI: begin
        o_ctrl_c.alu_src   = 1'b1;
        o_ctrl_c.reg_write = 1'b1;
        o_ctrl_c.alu_op    = ALU_OR;
        w_imm_sel          = IMM_ZERO;
      end
      OP_LUI: begin
        o_ctrl_c.alu_src   = 1'b1;
        o_ctrl_c.reg_write = 1'b1;
        o_ctrl_c.alu_op    = ALU_LUI;
        w_imm_sel          = IMM_UPPER;
      end
      default: o_ctrl_c.illegal = 1'b1;
    endcase
  end

  assign o_imm_c = extend_imm(w_imm_sel, i_instr[25:0]);

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode stage and ID/EX pipeline register: operand fetch with
// write-back bypass, forced-zero $zero, decode and load-use stall.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREG_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [INSTR_W-1:0]   id_instr,
  input  logic [XLEN-1:0]      id_pc_plus4,
  input  logic                 flush,
  output logic [NREG_BITS-1:0] rf_read_register1,
  output logic [NREG_BITS-1:0] rf_read_register2,
  input  logic [XLEN-1:0]      rf_read_data1,
  input  logic [XLEN-1:0]      rf_read_data2,
  input  logic                 wb_write_enable,
  input  logic [NREG_BITS-1:0] wb_write_register,
  input  logic [XLEN-1:0]      wb_in_data,
  output logic                 stall,
  output logic                 ex_valid,
  output logic [XLEN-1:0]      ex_pc_plus4,
  output logic [XLEN-1:0]      ex_rs_data,
  output logic [XLEN-1:0]      ex_rt_data,
  output logic [XLEN-1:0]      ex_imm,
  output logic [NREG_BITS-1:0] ex_rs,
  output logic [NREG_BITS-1:0] ex_rt,
  output logic [NREG_BITS-1:0] ex_dest,
  output logic [4:0]           ex_shamt,
  output logic [5:0]           ex_funct,
  output logic [ALU_OP_W-1:0]  ex_alu_op,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic                 ex_mem_to_reg,
  output logic                 ex_alu_src,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output logic                 ex_illegal
);

  logic [NREG_BITS-1:0] w_rs_idx;
  logic [NREG_BITS-1:0] w_rt_idx;
  logic [NREG_BITS-1:0] w_rd_idx;
  logic [XLEN-1:0]      w_rs_data;
  logic [XLEN-1:0]      w_rt_data;
  ctrl_t                w_ctrl;
  logic                 w_dest_rd;
  logic                 w_reads_rt;
  logic [INSTR_W-1:0]   w_imm;
  logic                 w_stall;
  logic                 w_bubble;

  ctrl_t                r_ctrl;
  logic                 r_valid;
  logic [XLEN-1:0]      r_pc_plus4;
  logic [XLEN-1:0]      r_rs_data;
  logic [XLEN-1:0]      r_rt_data;
  logic [XLEN-1:0]      r_imm;
  logic [NREG_BITS-1:0] r_rs;
  logic [NREG_BITS-1:0] r_rt;
  logic [NREG_BITS-1:0] r_dest;
  logic [4:0]           r_shamt;
  logic [5:0]           r_funct;

  assign w_rs_idx = NREG_BITS'(id_instr[25:21]);
  assign w_rt_idx = NREG_BITS'(id_instr[20:16]);
  assign w_rd_idx = NREG_BITS'(id_instr[15:11]);

  assign rf_read_register1 = w_rs_idx;
  assign rf_read_register2 = w_rt_idx;

  id_decoder u_decoder (
    .i_instr      (id_instr),
    .o_ctrl_c     (w_ctrl),
    .o_dest_rd_c  (w_dest_rd),
    .o_reads_rt_c (w_reads_rt),
    .o_imm_c      (w_imm)
  );

  // The register file returns the pre-write value during a WB cycle, so forward it here.
  assign w_rs_data = (w_rs_idx == '0) ? '0 :
                     (wb_write_enable && (wb_write_register == w_rs_idx)) ? wb_in_data :
                     rf_read_data1;
  assign w_rt_data = (w_rt_idx == '0) ? '0 :
                     (wb_write_enable && (wb_write_register == w_rt_idx)) ? wb_in_data :
                     rf_read_data2;

  assign w_stall = id_valid && !flush && r_valid && r_ctrl.mem_read && (r_rt != '0) &&
                   ((r_rt == w_rs_idx) || (w_reads_rt && (r_rt == w_rt_idx)));
  assign stall   = w_stall;

  assign w_bubble = flush || w_stall || !id_valid;

  // Bubbles clear valid and controls; data fields simply hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc_plus4 <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_dest     <= '0;
      r_shamt    <= '0;
      r_funct    <= '0;
    end else if (w_bubble) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid    <= 1'b1;
      r_ctrl     <= w_ctrl;
      r_pc_plus4 <= id_pc_plus4;
      r_rs_data  <= w_rs_data;
      r_rt_data  <= w_rt_data;
      r_imm      <= XLEN'(w_imm);
      r_rs       <= w_rs_idx;
      r_rt       <= w_rt_idx;
      r_dest     <= w_dest_rd ? w_rd_idx : w_rt_idx;
      r_shamt    <= id_instr[10:6];
      r_funct    <= id_instr[5:0];
    end
  end

  assign ex_valid      = r_valid;
  assign ex_pc_plus4   = r_pc_plus4;
  assign ex_rs_data    = r_rs_data;
  assign ex_rt_data    = r_rt_data;
  assign ex_imm        = r_imm;
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_dest       = r_dest;
  assign ex_shamt      = r_shamt;
  assign ex_funct      = r_funct;
  assign ex_alu_op     = r_ctrl.alu_op;
  assign ex_reg_write  = r_ctrl.reg_write;
  assign ex_mem_read   = r_ctrl.mem_read;
  assign ex_mem_write  = r_ctrl.mem_write;
  assign ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign ex_alu_src    = r_ctrl.alu_src;
  assign ex_branch     = r_ctrl.branch;
  assign ex_jump       = r_ctrl.jump;
  assign ex_illegal    = r_ctrl.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed test-plan steps followed by
// randomized traffic against a behavioural model of the decode rules.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        flush;
  logic [4:0]  rf_read_register1, rf_read_register2;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        wb_write_enable;
  logic [4:0]  wb_write_register;
  logic [31:0] wb_in_data;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dest, ex_shamt;
  logic [5:0]  ex_funct;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_alu_src, ex_branch, ex_jump, ex_illegal;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .NREG_BITS(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4), .flush(flush),
    .rf_read_register1(rf_read_register1), .rf_read_register2(rf_read_register2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_write_enable(wb_write_enable), .wb_write_register(wb_write_register),
    .wb_in_data(wb_in_data), .stall(stall), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_src(ex_alu_src), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_illegal(ex_illegal)
  );

  typedef struct packed {
    logic        reg_write, mem_read, mem_write, mem_to_reg;
    logic        alu_src, branch, jump, illegal;
    logic [3:0]  alu_op;
    logic        alu_known;
    logic        reads_rt;
    logic [4:0]  dest;
    logic [31:0] imm;
  } exp_t;

  int checks = 0;
  int errors = 0;

  // Model: expected EX contents plus the register a pending load will write (0 = none).
  logic        m_valid;
  int          m_load_rt;
  exp_t        e;
  logic [31:0] e_pc, e_rsd, e_rtd;
  int          e_rs, e_rt, e_shamt, e_funct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int shamt, input int funct);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(shamt), 6'(funct)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t r;
    int   op, imm16, rt, rd;
    op    = int'(ins >> 26);
    imm16 = int'(ins % 65536);
    rt    = int'((ins >> 16) % 32);
    rd    = int'((ins >> 11) % 32);
    r = '0;
    r.imm       = (imm16 >= 32768) ? 32'(imm16 - 65536) : 32'(imm16);
    r.dest      = 5'(rt);
    r.alu_op    = ALU_ADD;
    r.alu_known = 1'b1;
    case (op)
      'h00: begin r.reg_write = 1; r.dest = 5'(rd); r.alu_op = ALU_FUNCT; r.reads_rt = 1; end
      'h23: begin r.mem_read = 1; r.mem_to_reg = 1; r.alu_src = 1; r.reg_write = 1; end
      'h2B: begin r.mem_write = 1; r.alu_src = 1; r.reads_rt = 1; end
      'h04: begin r.branch = 1; r.alu_op = ALU_SUB; r.reads_rt = 1; end
      'h02: begin r.jump = 1; r.imm = ins % 32'h0400_0000; r.alu_known = 0; end
      'h08: begin r.alu_src = 1; r.reg_write = 1; end
      'h0A: begin r.alu_src = 1; r.reg_write = 1; r.alu_op = ALU_SLT; end
      'h0C: begin r.alu_src = 1; r.reg_write = 1; r.alu_op = ALU_AND; r.imm = 32'(imm16); end
      'h0D: begin r.alu_src = 1; r.reg_write = 1; r.alu_op = ALU_OR;  r.imm = 32'(imm16); end
      'h0F: begin r.alu_src = 1; r.reg_write = 1; r.alu_op = ALU_LUI;
                  r.imm = 32'(imm16) * 32'd65536; end
      default: begin r.illegal = 1; r.alu_known = 0; end
    endcase
    return r;
  endfunction

  // Architectural value of a register as seen by the instruction in ID.
  function automatic logic [31:0] ref_operand(input int idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (wb_write_enable && int'(wb_write_register) == idx) return wb_in_data;
    return rf;
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                       input logic we, input int wr, input logic [31:0] wd,
                       input logic v, input logic fl);
    id_instr          = ins;
    id_pc_plus4       = $urandom & 32'hFFFF_FFFC;
    rf_read_data1     = d1;
    rf_read_data2     = d2;
    wb_write_enable   = we;
    wb_write_register = 5'(wr);
    wb_in_data        = wd;
    id_valid          = v;
    flush             = fl;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".data"}, ex_pc_plus4 | ex_rs_data | ex_rt_data | ex_imm, 32'd0);
    chk({tag, ".fields"}, 32'({ex_rs, ex_rt, ex_dest, ex_shamt, ex_funct, ex_alu_op}), 32'd0);
    chk({tag, ".ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                              ex_alu_src, ex_branch, ex_jump, ex_illegal}), 32'd0);
  endtask

  task automatic check_ex(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".ctrl"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                                ex_alu_src, ex_branch, ex_jump, ex_illegal}),
          32'({e.reg_write, e.mem_read, e.mem_write, e.mem_to_reg,
               e.alu_src, e.branch, e.jump, e.illegal}));
      chk({tag, ".pc"}, ex_pc_plus4, e_pc);
      chk({tag, ".rsd"}, ex_rs_data, e_rsd);
      chk({tag, ".rtd"}, ex_rt_data, e_rtd);
      chk({tag, ".imm"}, ex_imm, e.imm);
      chk({tag, ".fields"}, 32'({ex_rs, ex_rt, ex_shamt, ex_funct}),
          32'({5'(e_rs), 5'(e_rt), 5'(e_shamt), 6'(e_funct)}));
      if (e.reg_write) chk({tag, ".dest"}, 32'(ex_dest), 32'(e.dest));
      if (e.alu_known) chk({tag, ".aluop"}, 32'(ex_alu_op), 32'(e.alu_op));
    end else begin
      chk({tag, ".bubble"}, 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                                  ex_alu_src, ex_branch, ex_jump, ex_illegal}), 32'd0);
    end
  endtask

  // One clock: check combinational outputs, advance the model, check EX after the edge.
  task automatic cycle(input string tag, output logic stalled);
    exp_t d;
    int   rs, rt;
    logic exp_stall;
    d  = ref_decode(id_instr);
    rs = int'((id_instr >> 21) % 32);
    rt = int'((id_instr >> 16) % 32);
    exp_stall = id_valid && !flush && (m_load_rt != 0) &&
                ((m_load_rt == rs) || (d.reads_rt && m_load_rt == rt));
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    chk({tag, ".ra"}, 32'({rf_read_register1, rf_read_register2}), 32'({5'(rs), 5'(rt)}));
    if (flush || exp_stall || !id_valid) begin
      m_valid   = 1'b0;
      m_load_rt = 0;
    end else begin
      m_valid   = 1'b1;
      e         = d;
      e_pc      = id_pc_plus4;
      e_rsd     = ref_operand(rs, rf_read_data1);
      e_rtd     = ref_operand(rt, rf_read_data2);
      e_rs      = rs;
      e_rt      = rt;
      e_shamt   = int'((id_instr >> 6) % 32);
      e_funct   = int'(id_instr % 64);
      m_load_rt = d.mem_read ? rt : 0;
    end
    @(posedge clk);
    #1;
    check_ex(tag);
    @(negedge clk);
    stalled = exp_stall;
  endtask

  initial begin
    logic st;
    logic held;
    int   ops [10] = '{'h00, 'h23, 'h2B, 'h04, 'h02, 'h08, 'h0A, 'h0C, 'h0D, 'h0F};
    int   bad [5]  = '{'h01, 'h03, 'h20, 'h3E, 'h3F};
    int   pick, op;

    rst = 1'b1;
    m_valid = 1'b0;
    m_load_rt = 0;
    e = '0;
    drive(32'd0, 32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    check_zero("por");
    rst = 1'b0;

    // Load captured, then asynchronous reset mid-cycle while a dependent add waits.
    drive(enc_i('h23, 16, 9, 4), 32'd50, 32'd60, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lw0", st);
    drive(enc_r(9, 10, 8, 0, 'h20), 32'd9, 32'd10, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    m_valid = 1'b0;
    m_load_rt = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle("add", st);
    chk("add.rs9", ex_rs_data, 32'd9);
    chk("add.rt10", ex_rt_data, 32'd10);
    chk("add.dest8", 32'(ex_dest), 32'd8);
    chk("add.rw", 32'(ex_reg_write), 32'd1);

    drive(enc_r(16, 9, 8, 0, 'h20), 32'd16, 32'd7, 1'b1, 16, 32'd100, 1'b1, 1'b0);
    cycle("bypass", st);
    chk("bypass.100", ex_rs_data, 32'd100);
    drive(enc_r(0, 9, 8, 0, 'h20), 32'd10, 32'd7, 1'b1, 0, 32'd20, 1'b1, 1'b0);
    cycle("zero", st);
    chk("zero.0", ex_rs_data, 32'd0);

    // Load-use on rs: one stall cycle, then the add issues.
    drive(enc_i('h23, 16, 9, 4), 32'd1, 32'd2, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lw1", st);
    drive(enc_r(9, 11, 10, 0, 'h20), 32'd3, 32'd4, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lu.stall", st);
    chk("lu.bubble", 32'(ex_valid), 32'd0);
    cycle("lu.issue", st);
    chk("lu.issued", 32'(ex_valid), 32'd1);
    // Load-use through sw's rt; addi does not read rt; a load to $zero never stalls.
    drive(enc_i('h23, 16, 9, 0), 32'd1, 32'd2, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lw2", st);
    drive(enc_i('h2B, 16, 9, 0), 32'd5, 32'd6, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("sw.stall", st);
    cycle("sw.issue", st);
    drive(enc_i('h23, 16, 9, 0), 32'd1, 32'd2, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lw3", st);
    drive(enc_i('h08, 0, 9, 5), 32'd5, 32'd6, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("addi.nostall", st);
    drive(enc_i('h23, 16, 0, 0), 32'd1, 32'd2, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lwz", st);
    drive(enc_r(0, 0, 8, 0, 'h20), 32'd5, 32'd6, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lwz.use", st);
    // Flush beats the load-use stall.
    drive(enc_i('h23, 16, 9, 0), 32'd1, 32'd2, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lw4", st);
    drive(enc_r(9, 11, 10, 0, 'h20), 32'd3, 32'd4, 1'b0, 0, 32'd0, 1'b1, 1'b1);
    cycle("flush", st);
    chk("flush.nostall_bubble", 32'(ex_valid), 32'd0);

    drive(enc_i('h0D, 0, 9, 'h8000), 32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("ori", st);
    chk("ori.imm", ex_imm, 32'h0000_8000);
    drive(enc_i('h08, 0, 9, 'h8000), 32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("addi", st);
    chk("addi.imm", ex_imm, 32'hFFFF_8000);
    drive(enc_i('h0F, 0, 9, 'h1234), 32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("lui", st);
    chk("lui.imm", ex_imm, 32'h1234_0000);
    drive(enc_i('h3F, 1, 2, 3), 32'd0, 32'd0, 1'b0, 0, 32'd0, 1'b1, 1'b0);
    cycle("illegal", st);
    chk("illegal.flag", 32'(ex_illegal), 32'd1);
    chk("illegal.ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
                            ex_branch, ex_jump}), 32'd0);

    // Random traffic on a small register window to provoke hazards and bypasses.
    held = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (!held) begin
        pick = int'($urandom_range(0, 11));
        op   = (pick < 10) ? ops[pick] : bad[$urandom_range(0, 4)];
        if (op == 'h02) id_instr = {6'h02, 26'($urandom)};
        else id_instr = {6'(op), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                         16'($urandom)};
        id_pc_plus4 = $urandom & 32'hFFFF_FFFC;
        id_valid    = ($urandom_range(0, 9) != 0);
      end
      rf_read_data1     = $urandom;
      rf_read_data2     = $urandom;
      wb_write_enable   = 1'($urandom_range(0, 1));
      wb_write_register = 5'($urandom_range(0, 3));
      wb_in_data        = $urandom;
      flush             = ($urandom_range(0, 9) == 0);
      cycle("rand", held);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
